data_mem_arb: RTL



---
 rtl/data_mem_arb.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_arb.sv
// data_mem_arb: one write port and RD_CH read channels sharing one on-chip
// array, serialised by an IDLE/WRITE/READ FSM (writes and reads interleave
// fairly, reads are served round-robin across channels).
// Ports:
//   clk, reset       single clock; synchronous active-low reset
//   wr_en            write request (active-low), held until wr_ack
//   wr_addr/wr_data  write address / data
//   wr_ack           one-cycle pulse, write accepted
//   rd_en            per-channel read request (active-low), held until rd_valid
//   rd_addr          packed addresses, ch c at [c*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data          packed registered read data, same packing
//   rd_valid         per-channel one-cycle pulse, rd_data of that ch updated
//   busy             high while requests are ignored
// Optional macro MEM_CLEAR_EN: zero the whole array after every reset
// (CLEAR state, busy high); without it busy is tied low.

module data_mem_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
   parameter int RD_CH      = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wr_en,
   input  logic [ADDR_WIDTH-1:0]       wr_addr,
   input  logic [DATA_WIDTH-1:0]       wr_data,
   output logic                        wr_ack,
   input  logic [RD_CH-1:0]            rd_en,
   input  logic [RD_CH*ADDR_WIDTH-1:0] rd_addr,
   output logic [RD_CH*DATA_WIDTH-1:0] rd_data,
   output logic [RD_CH-1:0]            rd_valid,
   output logic                        busy
);

   localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CW = (RD_CH > 1) ? $clog2(RD_CH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

`ifdef MEM_CLEAR_EN
   typedef enum logic [1:0] {IDLE, WRITE, READ, CLEAR} state_t;
   localparam logic [IW-1:0] CLR_LAST = IW'(MEM_DEPTH - 1);
   logic [IW-1:0] clr_cnt;
`else
   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
`endif

   typedef enum logic {OP_WRITE, OP_READ} op_t;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   state_t                state, state_nxt;
   op_t                   last_op;
   logic [CW-1:0]         rr_ptr, ch_q, sel_ch, cand;
   logic                  sel_ok;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [RD_CH-1:0]      elig, rd_valid_q;
   logic [DATA_WIDTH-1:0] rd_q [RD_CH];
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  wr_in, rd_in;
   logic                  mem_we;
   logic [IW-1:0]         mem_wa;
   logic [DATA_WIDTH-1:0] mem_wd;

   // Out-of-range addresses: writes dropped, reads return zero.
   assign wr_in   = {1'b0, wr_addr} < DEPTH;
   assign rd_in   = {1'b0, addr_q} < DEPTH;
   assign rd_word = rd_in ? mem[addr_q[IW-1:0]] : '0;

   // A channel whose valid is showing still holds its enable low for this
   // one cycle; masking it stops the same request being served twice.
   always_comb begin
      elig   = ~rd_en & ~rd_valid_q;
      sel_ch = '0;
      sel_ok = 1'b0;
      cand   = '0;
      for (int i = 1; i <= RD_CH; i++) begin
         if (int'(rr_ptr) + i >= RD_CH)
            cand = CW'(int'(rr_ptr) + i - RD_CH);
         else
            cand = CW'(int'(rr_ptr) + i);
         if (!sel_ok && elig[cand]) begin
            sel_ok = 1'b1;
            sel_ch = cand;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      wr_ack    = 1'b0;
      mem_we    = 1'b0;
      mem_wa    = wr_addr[IW-1:0];
      mem_wd    = wr_data;
      unique case (state)
         IDLE: begin
            if (!wr_en && (last_op == OP_READ || !(|elig)))
               state_nxt = WRITE;
            else if (sel_ok)
               state_nxt = READ;
         end
         WRITE: begin
            // Reset landing in this cycle kills both the ack and the write.
            wr_ack    = reset;
            mem_we    = reset & wr_in;
            state_nxt = IDLE;
         end
         READ: state_nxt = IDLE;
`ifdef MEM_CLEAR_EN
         CLEAR: begin
            mem_we = reset;
            mem_wa = clr_cnt;
            mem_wd = '0;
            if (clr_cnt == CLR_LAST)
               state_nxt = IDLE;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
`ifdef MEM_CLEAR_EN
         state   <= CLEAR;
         clr_cnt <= '0;
`else
         state   <= IDLE;
`endif
         last_op    <= OP_READ;
         rr_ptr     <= CW'(RD_CH - 1);
         ch_q       <= '0;
         addr_q     <= '0;
         rd_valid_q <= '0;
         for (int c = 0; c < RD_CH; c++)
            rd_q[c] <= '0;
      end else begin
         state      <= state_nxt;
         rd_valid_q <= '0;
         if (state == IDLE && state_nxt == READ) begin
            ch_q   <= sel_ch;
            addr_q <= rd_addr[sel_ch*ADDR_WIDTH +: ADDR_WIDTH];
         end
         if (state == WRITE)
            last_op <= OP_WRITE;
         if (state == READ) begin
            rd_q[ch_q]       <= rd_word;
            rd_valid_q[ch_q] <= 1'b1;
            rr_ptr           <= ch_q;
            last_op          <= OP_READ;
         end
`ifdef MEM_CLEAR_EN
         if (state == CLEAR)
            clr_cnt <= clr_cnt + 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_wa] <= mem_wd;
   end

   for (genvar c = 0; c < RD_CH; c++) begin : g_out
      assign rd_data[c*DATA_WIDTH +: DATA_WIDTH] = rd_q[c];
   end

   assign rd_valid = rd_valid_q;

`ifdef MEM_CLEAR_EN
   assign busy = ~reset | (state == CLEAR);
`else
   assign busy = 1'b0;
`endif

endmodule
